// File: rtl/paper_arb_pkg.sv
// paper_arb_pkg: shared state type, default sizes and one-hot decode helper for the paper-count arbiter
package paper_arb_pkg;

    typedef enum logic {IDLE, UPDATE} state_t;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 2;

    // Index of the set bit in a one-hot vector; requester count is capped at 8
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < 8; k++)
            if (oh[k]) idx = 3'(k);
        return idx;
    endfunction

endpackage

// File: rtl/paper_count_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at ptr, returns one-hot winner and its index
module rr_picker
    import paper_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] elig,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    logic [N_REQ-1:0] cand;

    assign cand = req & elig;
    assign any  = |cand;

    // Walk offsets from farthest to nearest so the candidate closest to ptr is kept last
    always_comb begin
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            for (int i = 0; i < N_REQ; i++)
                if (cand[i] && i == (int'(ptr) + k) % N_REQ) begin
                    win    = '0;
                    win[i] = 1'b1;
                end
    end

    assign win_idx = IW'(oh_to_idx(8'(win)));

endmodule

// File: rtl/paper_count_arbiter.sv
// paper_count_arbiter: round-robin sequencer sharing one count register among feeders; PAPER_ARB_SATURATE_EN selects saturating count with sticky ovf
module paper_count_arbiter
    import paper_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             clear,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic             busy
);

    localparam int IW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx, ptr_nxt;
    logic             any;

    // A feeder being acked this cycle is still dropping its request, so mask it out
    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req     (req),
        .elig    (~ack_q),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign ptr_nxt = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);

    // Next state: latch a winner in IDLE, commit increment and ack in UPDATE; clear overrides the count
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        ack_d   = '0;
        ptr_d   = ptr_q;
        count_d = count_q;
`ifdef PAPER_ARB_SATURATE_EN
        ovf_d   = ovf_q;
`else
        ovf_d   = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (any) begin
                state_d = UPDATE;
                grant_d = win;
                ptr_d   = ptr_nxt;
            end
        end else begin
            state_d = IDLE;
            ack_d   = grant_q;
`ifdef PAPER_ARB_SATURATE_EN
            count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
            ovf_d   = ovf_q | (&count_q);
`else
            count_d = count_q + CNT_W'(1);
            ovf_d   = &count_q;
`endif
        end
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and output registers; reset abandons any pending grant
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;
    assign ack   = ack_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);

endmodule
